// File: rtl/regfile_sb_if.sv
// Bus between decode/issue, writeback and the register file: read, write and issue channels.
// The master side drives indices/strobes; the register file is the slave.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic                wr_en;
    logic [AW-1:0]       wr_idx_in;
    logic [XLEN-1:0]     wr_data_in;
    logic [NRD*AW-1:0]   rd_idx_in;
    logic [NRD*XLEN-1:0] rd_data_out;
    logic [NRD-1:0]      rd_busy_out;
    logic                iss_en;
    logic [AW-1:0]       iss_idx_in;
    logic                iss_ready_out;
    logic [AW:0]         busy_cnt_out;

    modport master (
        output wr_en, wr_idx_in, wr_data_in, rd_idx_in, iss_en, iss_idx_in,
        input  rd_data_out, rd_busy_out, iss_ready_out, busy_cnt_out
    );

    modport slave (
        input  wr_en, wr_idx_in, wr_data_in, rd_idx_in, iss_en, iss_idx_in,
        output rd_data_out, rd_busy_out, iss_ready_out, busy_cnt_out
    );
endinterface

// File: rtl/regfile_sb.sv
// RV32I integer register file: NRD combinational read ports, one write port, x0 hardwired
// to zero, optional write-to-read bypass, and a busy-bit scoreboard with a popcount counter.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic          clkin,
    input  logic          nrst_in,
    regfile_sb_if.slave   bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NREGS-1:0]    r_busy;
    logic [AW:0]         r_busy_cnt;

    logic                w_wb_go;
    logic                w_iss_wb_hit;
    logic                w_iss_ready;
    logic                w_iss_go;
    logic                w_inc;
    logic                w_dec;
    logic [AW-1:0]       w_idx;
    logic                w_hit;
    logic [NRD*XLEN-1:0] w_rd_data;
    logic [NRD-1:0]      w_rd_busy;

    assign w_wb_go      = bus.wr_en && (bus.wr_idx_in != '0);
    assign w_iss_wb_hit = bus.wr_en && (bus.wr_idx_in == bus.iss_idx_in);
    assign w_iss_ready  = !r_busy[bus.iss_idx_in] || w_iss_wb_hit || (bus.iss_idx_in == '0);
    assign w_iss_go     = bus.iss_en && w_iss_ready && (bus.iss_idx_in != '0);

    // A reissue onto a register retiring on the same edge leaves its busy bit at 1,
    // so neither a set nor a clear is counted for it.
    assign w_inc = w_iss_go && !r_busy[bus.iss_idx_in];
    assign w_dec = w_wb_go && r_busy[bus.wr_idx_in] &&
                   !(w_iss_go && (bus.iss_idx_in == bus.wr_idx_in));

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_idx     = '0;
        w_hit     = 1'b0;
        for (int unsigned k = 0; k < NRD; k++) begin
            w_idx = bus.rd_idx_in[k*AW +: AW];
            w_hit = (BYPASS != 0) && bus.wr_en && (bus.wr_idx_in == w_idx);
            if (w_idx == '0)
                w_rd_data[k*XLEN +: XLEN] = '0;
            else if (w_hit)
                w_rd_data[k*XLEN +: XLEN] = bus.wr_data_in;
            else
                w_rd_data[k*XLEN +: XLEN] = r_regs[w_idx];
            w_rd_busy[k] = r_busy[w_idx] && !w_hit;
        end
    end

    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wb_go) begin
                r_regs[bus.wr_idx_in] <= bus.wr_data_in;
                r_busy[bus.wr_idx_in] <= 1'b0;
            end
            // Issue is assigned last so it overrides a same-edge clear of the same index.
            if (w_iss_go)
                r_busy[bus.iss_idx_in] <= 1'b1;
            r_busy_cnt <= r_busy_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    assign bus.rd_data_out   = w_rd_data;
    assign bus.rd_busy_out   = w_rd_busy;
    assign bus.iss_ready_out = w_iss_ready;
    assign bus.busy_cnt_out  = r_busy_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share one stimulus stream.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                nrst;
    logic                wr_en;
    logic [AW-1:0]       wr_idx;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rd_idx;
    logic                iss_en;
    logic [AW-1:0]       iss_idx;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus1 ();
    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus0 ();

    assign bus1.wr_en      = wr_en;
    assign bus1.wr_idx_in  = wr_idx;
    assign bus1.wr_data_in = wr_data;
    assign bus1.rd_idx_in  = rd_idx;
    assign bus1.iss_en     = iss_en;
    assign bus1.iss_idx_in = iss_idx;
    assign bus0.wr_en      = wr_en;
    assign bus0.wr_idx_in  = wr_idx;
    assign bus0.wr_data_in = wr_data;
    assign bus0.rd_idx_in  = rd_idx;
    assign bus0.iss_en     = iss_en;
    assign bus0.iss_idx_in = iss_idx;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_byp (
        .clkin   (clk),
        .nrst_in (nrst),
        .bus     (bus1.slave)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nob (
        .clkin   (clk),
        .nrst_in (nrst),
        .bus     (bus0.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_idx = '0;
    endtask

    initial begin
        nrst   = 1'b0;
        rd_idx = '0;
        idle();
        #2;
        check("rst_rd0",    {32'h0, bus1.rd_data_out[31:0]}, 64'h0);
        check("rst_cnt",    {59'h0, bus1.busy_cnt_out}, 64'h0);
        check("rst_ready",  {63'h0, bus1.iss_ready_out}, 64'h1);
        check("rst_busy",   {62'h0, bus1.rd_busy_out}, 64'h0);
        #10 nrst = 1'b1;
        step();

        // 1: reset while holding data and a busy bit
        wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_idx = 5'd4;
        step();
        idle();
        rd_idx = {5'd0, 5'd5};
        #1;
        check("t1_x5",      {32'h0, bus1.rd_data_out[31:0]}, 64'hDEADBEEF);
        check("t1_cnt1",    {59'h0, bus1.busy_cnt_out}, 64'h1);
        #1 nrst = 1'b0;
        #1;
        check("t1_rst_x5",  {32'h0, bus1.rd_data_out[31:0]}, 64'h0);
        check("t1_rst_cnt", {59'h0, bus1.busy_cnt_out}, 64'h0);
        #1 nrst = 1'b1;
        step();
        check("t1_after_x5", {32'h0, bus0.rd_data_out[31:0]}, 64'h0);

        // 2: x0 ignores writes, always ready, no scoreboard effect
        wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_idx = 5'd0;
        rd_idx = {5'd0, 5'd0};
        #1;
        check("t2_byp_p0",  {32'h0, bus1.rd_data_out[31:0]}, 64'h0);
        check("t2_byp_p1",  {32'h0, bus1.rd_data_out[63:32]}, 64'h0);
        check("t2_ready",   {63'h0, bus1.iss_ready_out}, 64'h1);
        step();
        idle();
        #1;
        check("t2_nob_p0",  {32'h0, bus0.rd_data_out[31:0]}, 64'h0);
        check("t2_cnt",     {59'h0, bus1.busy_cnt_out}, 64'h0);

        // 3: bypass vs stored value
        wr_en = 1'b1; wr_idx = 5'd7; wr_data = 32'h11111111;
        step();
        wr_data = 32'h12345678;
        rd_idx  = {5'd0, 5'd7};
        #1;
        check("t3_byp_same", {32'h0, bus1.rd_data_out[31:0]}, 64'h12345678);
        check("t3_nob_same", {32'h0, bus0.rd_data_out[31:0]}, 64'h11111111);
        step();
        idle();
        #1;
        check("t3_byp_next", {32'h0, bus1.rd_data_out[31:0]}, 64'h12345678);
        check("t3_nob_next", {32'h0, bus0.rd_data_out[31:0]}, 64'h12345678);

        // 4: RAW on port 1, resolved in the writeback cycle only with bypass
        iss_en = 1'b1; iss_idx = 5'd3;
        #1;
        check("t4_ready",   {63'h0, bus1.iss_ready_out}, 64'h1);
        step();
        idle();
        rd_idx = {5'd3, 5'd0};
        #1;
        check("t4_busy",    {62'h0, bus1.rd_busy_out}, 64'h2);
        check("t4_cnt1",    {59'h0, bus1.busy_cnt_out}, 64'h1);
        wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'h0000AAAA;
        #1;
        check("t4_wb_byp",  {62'h0, bus1.rd_busy_out}, 64'h0);
        check("t4_wb_nob",  {62'h0, bus0.rd_busy_out}, 64'h2);
        check("t4_wb_data", {32'h0, bus1.rd_data_out[63:32]}, 64'h0000AAAA);
        step();
        idle();
        #1;
        check("t4_cnt0",    {59'h0, bus1.busy_cnt_out}, 64'h0);
        check("t4_nob_clr", {62'h0, bus0.rd_busy_out}, 64'h0);

        // 5: WAW blocking and same-edge reissue
        iss_en = 1'b1; iss_idx = 5'd9;
        step();
        #1;
        check("t5_blocked", {63'h0, bus1.iss_ready_out}, 64'h0);
        step();
        check("t5_hold_cnt", {59'h0, bus1.busy_cnt_out}, 64'h1);
        wr_en = 1'b1; wr_idx = 5'd9; wr_data = 32'h99;
        #1;
        check("t5_reiss_rdy", {63'h0, bus1.iss_ready_out}, 64'h1);
        step();
        idle();
        rd_idx = {5'd9, 5'd0};
        #1;
        check("t5_reiss_cnt",  {59'h0, bus1.busy_cnt_out}, 64'h1);
        check("t5_reiss_busy", {62'h0, bus1.rd_busy_out}, 64'h2);
        wr_en = 1'b1; wr_idx = 5'd9;
        step();
        idle();
        check("t5_clear", {59'h0, bus1.busy_cnt_out}, 64'h0);

        // 6: fill the scoreboard, drain it, then stray and mixed traffic
        for (int i = 1; i < NREGS; i++) begin
            iss_en = 1'b1; iss_idx = AW'(i);
            step();
        end
        idle();
        check("t6_full",    {59'h0, bus1.busy_cnt_out}, 64'd31);
        check("t6_full_nb", {59'h0, bus0.busy_cnt_out}, 64'd31);
        iss_idx = 5'd17;
        #1;
        check("t6_full_blk", {63'h0, bus1.iss_ready_out}, 64'h0);
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; wr_idx = AW'(i); wr_data = 32'(i);
            step();
        end
        idle();
        check("t6_drained", {59'h0, bus1.busy_cnt_out}, 64'h0);
        wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'h5A5A;
        step();
        idle();
        check("t6_stray",   {59'h0, bus1.busy_cnt_out}, 64'h0);
        iss_en = 1'b1; iss_idx = 5'd10;
        step();
        iss_idx = 5'd11;
        wr_en = 1'b1; wr_idx = 5'd10;
        step();
        idle();
        check("t6_swap_cnt", {59'h0, bus1.busy_cnt_out}, 64'h1);
        rd_idx = {5'd11, 5'd10};
        #1;
        check("t6_swap_busy", {62'h0, bus1.rd_busy_out}, 64'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the RV32I core, with N combinational read ports, one write port, hardwired-zero register 0 and write-to-read bypass. Adds a per-register scoreboard (busy bits plus an outstanding-write counter) so the pipelined issue stage can detect RAW/WAW hazards. Sits between decode/issue (read and issue ports) and writeback (write port).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers; power of two, >= 2
AW, $clog2(NREGS), index width; derived localparam, not overridable
NRD, 2, number of read ports, 1..4
BYPASS, 1, 1 = read data returns same-cycle write data on index match; 0 = returns stored value

Ports:
clkin  input  1  clock, rising edge
nrst_in  input  1  asynchronous active-low reset
wr_en  input  1  writeback strobe
wr_idx_in  input  AW  writeback register index
wr_data_in  input  XLEN  writeback data
rd_idx_in  input  NRD*AW  packed read indices; port k = bits [k*AW +: AW]
rd_data_out  output  NRD*XLEN  packed read data; port k = bits [k*XLEN +: XLEN]
rd_busy_out  output  NRD  port k source has an outstanding write not being retired this cycle
iss_en  input  1  issue strobe: instruction with destination iss_idx_in enters pipeline
iss_idx_in  input  AW  destination of issuing instruction
iss_ready_out  output  1  issue accepted this cycle
busy_cnt_out  output  AW+1  number of registers currently marked busy

Behaviour:
- Reset (nrst_in low, asynchronous, effective immediately regardless of clkin): all registers = 0, all busy bits = 0, busy_cnt_out = 0. rd_data_out therefore reads 0 during reset; rd_busy_out = 0; iss_ready_out = 1 when not otherwise blocked. Reset asserted mid-operation discards in-flight writes and issues.
- Register 0: always reads 0. Writes to it are ignored. Its busy bit is never set, and an issue to index 0 is always ready and has no scoreboard effect.
- Write: on rising clkin with wr_en=1 and wr_idx_in!=0, reg[wr_idx_in] <= wr_data_in. The busy bit of wr_idx_in clears on the same edge.
- Read: combinational, zero latency. Port k: if idx==0 -> 0; else if BYPASS and wr_en and wr_idx_in==idx -> wr_data_in; else reg[idx].
- rd_busy_out[k] = busy[idx_k] and not (wr_en and wr_idx_in==idx_k). A same-cycle writeback resolves the hazard in this cycle when BYPASS=1. When BYPASS=0, the wr_en term is omitted.
- Issue: iss_ready_out = not busy[iss_idx_in] or (wr_en and wr_idx_in==iss_idx_in) or iss_idx_in==0. Only one outstanding producer per register is allowed (WAW blocks).
- On a rising edge with iss_en and iss_ready_out and iss_idx_in!=0: busy[iss_idx_in] <= 1. This takes priority over a same-edge clear for the same index, so the busy bit stays 1.
- iss_en with iss_ready_out=0: no state change. The caller holds the request and retries.
- Writeback to a non-busy register: the data is written and the busy bit stays 0. The counter does not underflow.
- busy_cnt_out: registered. Next value = current + set − clear, where set means a busy bit goes 0→1 and clear means a busy bit goes 1→0. The counter must equal the popcount of the busy bits at all times. Maximum value is NREGS−1.
- No X propagation: out-of-range indices cannot occur because NREGS is a power of two.

Test Plan:
1. Reset while regs hold data: write 0xDEADBEEF to x5, pulse nrst_in low between edges -> rd_data_out(x5)=0 immediately, busy_cnt_out=0.
2. x0: wr_en, idx 0, data 0xFFFFFFFF; read idx 0 on both ports; issue to idx 0 -> reads 0, iss_ready_out=1, busy_cnt_out unchanged.
3. Bypass with BYPASS=1: write 0x12345678 to x7 while port0 reads x7 in the same cycle -> 0x12345678 in that cycle. Repeat with BYPASS=0 -> old value that cycle, new value next cycle.
4. Scoreboard RAW: issue x3, then port1 reads x3 -> rd_busy_out[1]=1, busy_cnt_out=1. Writeback x3 -> rd_busy_out[1]=0 in the writeback cycle, busy_cnt_out=0 after the edge.
5. WAW block and same-edge reissue: issue x9; issue x9 again -> iss_ready_out=0. Issue x9 on the same edge as writeback x9 -> accepted, busy[9] remains 1, busy_cnt_out=1.
6. Fill: issue x1..x31 on successive edges, no writebacks -> busy_cnt_out=31. Stray writeback to an idle register after all are cleared -> busy_cnt_out stays 0.
